// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one registered ALU among NUM_REQ valid/ready requesters.
// Optional build macro ALU_ARB_PERF_EN adds ops_done (saturating) and busy outputs.

module alu_rr_lane #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 4,
  parameter int IDX_W = 2,
  parameter int IDX   = 0
) (
  input  logic [WIDTH-1:0] a_slice,
  input  logic [WIDTH-1:0] b_slice,
  input  logic [SEL_W-1:0] sel_slice,
  input  logic [IDX_W-1:0] gnt_idx,
  input  logic [IDX_W-1:0] grant,
  input  logic             offer,
  input  logic             respond,
  output logic             ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [SEL_W-1:0] op_sel
);
  logic hit;

  assign hit       = (gnt_idx == IDX_W'(IDX));
  assign ready     = offer & hit;
  assign rsp_valid = respond & (grant == IDX_W'(IDX));
  // AND-OR mux slice: only the arbitration winner contributes its operands
  assign op_a      = hit ? a_slice   : '0;
  assign op_b      = hit ? b_slice   : '0;
  assign op_sel    = hit ? sel_slice : '0;
endmodule

module alu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int SEL_W   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*SEL_W-1:0] req_sel,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_y,
  output logic                     rsp_c,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [SEL_W-1:0]         alu_sel,
  input  logic [WIDTH-1:0]         alu_y,
  input  logic                     alu_c
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [15:0]              ops_done,
  output logic                     busy
`endif
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_RESPOND = 2'd3;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SEL_W-1:0] sel;
  } alu_req_t;

  logic [1:0]                    state;
  logic [IDX_W-1:0]              rr_ptr, grant, gnt_idx;
  logic                          gnt_found, offer, respond;
  logic [CNT_W-1:0]              wait_cnt;
  logic [NUM_REQ-1:0][WIDTH-1:0] lane_a, lane_b;
  logic [NUM_REQ-1:0][SEL_W-1:0] lane_sel;
  alu_req_t                      op_req, op_reg;

  // Rotating priority search starting at rr_ptr
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!gnt_found && req_valid[j[IDX_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = j[IDX_W-1:0];
      end
    end
  end

  assign offer   = rst & (state == ST_IDLE) & gnt_found;
  assign respond = rst & (state == ST_RESPOND);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    alu_rr_lane #(
      .WIDTH(WIDTH), .SEL_W(SEL_W), .IDX_W(IDX_W), .IDX(i)
    ) u_lane (
      .a_slice   (req_a[i*WIDTH +: WIDTH]),
      .b_slice   (req_b[i*WIDTH +: WIDTH]),
      .sel_slice (req_sel[i*SEL_W +: SEL_W]),
      .gnt_idx   (gnt_idx),
      .grant     (grant),
      .offer     (offer),
      .respond   (respond),
      .ready     (req_ready[i]),
      .rsp_valid (rsp_valid[i]),
      .op_a      (lane_a[i]),
      .op_b      (lane_b[i]),
      .op_sel    (lane_sel[i])
    );
  end

  always_comb begin
    op_req = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      op_req.a   = op_req.a   | lane_a[k];
      op_req.b   = op_req.b   | lane_b[k];
      op_req.sel = op_req.sel | lane_sel[k];
    end
  end

  // Operand registers load at the handshake so the ALU sees them during ISSUE
  assign alu_a   = op_reg.a;
  assign alu_b   = op_reg.b;
  assign alu_sel = op_reg.sel;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      op_reg   <= '0;
      wait_cnt <= '0;
      rsp_y    <= '0;
      rsp_c    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_found) begin
            op_reg <= op_req;
            grant  <= gnt_idx;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= CNT_W'(ALU_LAT - 1);
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            rsp_y <= alu_y;
            rsp_c <= alu_c;
            state <= ST_RESPOND;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_RESPOND: begin
          rr_ptr <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst)
      ops_done <= '0;
    else if (state == ST_RESPOND && ops_done != 16'hFFFF)
      ops_done <= ops_done + 16'd1;
  end

  assign busy = (state != ST_IDLE);
`endif

endmodule
